// File: rtl/register_scoreboard_pkg.sv
// Pipeline_Pkg
// Shared definitions for the register scoreboard: register-file geometry,
// shadow-pipeline depth, the shadow entry record and the producer test.
// No ports (package).
package Pipeline_Pkg;

  localparam int REG_W      = 5;
  localparam int NUM_REGS   = 32;
  localparam int PIPE_DEPTH = 3;

  // One shadow-pipeline slot: what the real EX/MEM/WB stage holds, reduced
  // to the information needed to track pending register writes.
  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } entry_t;

  // An entry only counts as a pending write when it is a real instruction
  // that writes a register other than x0 (x0 writes are discarded).
  function automatic logic is_producer(entry_t e);
    return e.valid & e.reg_write & (e.rd != '0);
  endfunction

endpackage

// File: rtl/register_scoreboard_hazard_compare.sv
// Hazard_Compare
// Compares one source operand of the instruction in ID against one shadow
// pipeline entry and flags a read-after-write conflict.
// Ports:
//   producer_i  - shadow entry being checked (normally the EX entry)
//   src_used_i  - the source is really read by a valid ID instruction
//   src_i       - source register number
//   match_o     - 1 when the source depends on the entry's pending write
module Hazard_Compare
  import Pipeline_Pkg::*;
(
  input  entry_t           producer_i,
  input  logic             src_used_i,
  input  logic [REG_W-1:0] src_i,
  output logic             match_o
);

  // x0 reads never conflict, even if a stale entry names x0.
  assign match_o = src_used_i & (src_i != '0) & is_producer(producer_i) &
                   (producer_i.rd == src_i);

endmodule

// File: rtl/register_scoreboard.sv
// register_scoreboard
// Tracks the destination registers of instructions in EX, MEM and WB with a
// shadow pipeline, stalls ID for one cycle when it reads the register being
// produced in EX (MEM/WB results reach it via forwarding or the register
// file), publishes a busy bit per register and counts stalled cycles.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   issue_valid          - ID holds a valid instruction
//   issue_RegWrite/Rd    - ID destination write enable / register
//   issue_Rs1/Rs2        - ID source registers
//   issue_uses_rs1/rs2   - the matching source is actually read
//   kill_ex              - squash the instruction entering EX this cycle
//   issue_ready          - ID may advance (0 stalls PC and IF/ID)
//   hazard_rs1/rs2       - per-source hazard against the EX entry
//   busy_vector          - bit r set while a write to xr is in flight
//   stall_count          - saturating count of stalled cycles
module register_scoreboard
  import Pipeline_Pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_RegWrite,
  input  logic [REG_W-1:0]    issue_Rd,
  input  logic [REG_W-1:0]    issue_Rs1,
  input  logic [REG_W-1:0]    issue_Rs2,
  input  logic                issue_uses_rs1,
  input  logic                issue_uses_rs2,
  input  logic                kill_ex,
  output logic                issue_ready,
  output logic                hazard_rs1,
  output logic                hazard_rs2,
  output logic [NUM_REGS-1:0] busy_vector,
  output logic [CNT_W-1:0]    stall_count
);

  // Index 0 is EX, 1 is MEM, 2 is WB.
  entry_t           pipe_q [PIPE_DEPTH];
  entry_t           ex_d;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  // Only the EX entry can cause a stall; older producers are forwarded.
  Hazard_Compare u_hazard_rs1 (
    .producer_i (pipe_q[0]),
    .src_used_i (issue_valid & issue_uses_rs1),
    .src_i      (issue_Rs1),
    .match_o    (hazard_rs1)
  );

  Hazard_Compare u_hazard_rs2 (
    .producer_i (pipe_q[0]),
    .src_used_i (issue_valid & issue_uses_rs2),
    .src_i      (issue_Rs2),
    .match_o    (hazard_rs2)
  );

  // A stall or a kill both turn the incoming EX slot into a bubble; the kill
  // does not mask the hazard, so issue_ready still reports the stall.
  always_comb begin
    issue_ready         = ~(hazard_rs1 | hazard_rs2);
    ex_d.valid          = issue_valid & issue_ready & ~kill_ex;
    ex_d.reg_write      = issue_RegWrite;
    ex_d.rd             = issue_Rd;
    stall_count_d       = stall_count_q;
    if (issue_valid & ~issue_ready & ~(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Busy bits are recomputed from all in-flight producers, so a register
  // written by several entries stays busy until the last one retires.
  always_comb begin
    busy_vector = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (is_producer(pipe_q[i])) begin
        busy_vector[pipe_q[i].rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      pipe_q[0] <= ex_d;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard
// Directed bench for register_scoreboard. Two instances share the stimulus:
// one with the default 16-bit counter and one with a 4-bit counter to show
// saturation. A history-based model of the last three issued instructions
// predicts every output on each falling edge; directed literal checks pin
// the expected behaviour of the model and DUT at key points.
module tb_register_scoreboard;

  logic        clk;
  logic        rst;
  logic        issueValid;
  logic        issueRegWrite;
  logic [4:0]  issueRd;
  logic [4:0]  issueRs1;
  logic [4:0]  issueRs2;
  logic        issueUsesRs1;
  logic        issueUsesRs2;
  logic        killEx;

  logic        ready16, haz1_16, haz2_16;
  logic [31:0] busy16;
  logic [15:0] stall16;
  logic        ready4, haz1_4, haz2_4;
  logic [31:0] busy4;
  logic [3:0]  stall4;

  int vectors     = 0;
  int miscompares = 0;

  register_scoreboard dut16 (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issueValid),
    .issue_RegWrite (issueRegWrite),
    .issue_Rd       (issueRd),
    .issue_Rs1      (issueRs1),
    .issue_Rs2      (issueRs2),
    .issue_uses_rs1 (issueUsesRs1),
    .issue_uses_rs2 (issueUsesRs2),
    .kill_ex        (killEx),
    .issue_ready    (ready16),
    .hazard_rs1     (haz1_16),
    .hazard_rs2     (haz2_16),
    .busy_vector    (busy16),
    .stall_count    (stall16)
  );

  register_scoreboard #(.CNT_W(4)) dut4 (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issueValid),
    .issue_RegWrite (issueRegWrite),
    .issue_Rd       (issueRd),
    .issue_Rs1      (issueRs1),
    .issue_Rs2      (issueRs2),
    .issue_uses_rs1 (issueUsesRs1),
    .issue_uses_rs2 (issueUsesRs2),
    .kill_ex        (killEx),
    .issue_ready    (ready4),
    .hazard_rs1     (haz1_4),
    .hazard_rs2     (haz2_4),
    .busy_vector    (busy4),
    .stall_count    (stall4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the last three instructions that actually entered EX, newest
  // first, plus the number of stalled cycles seen since reset.
  typedef struct {
    bit v;
    bit w;
    int rd;
  } hist_t;

  hist_t hist [3];
  int    mStalls;

  function automatic bit writesReg(hist_t h);
    return h.v && h.w && (h.rd != 0);
  endfunction

  function bit mHazard(bit uses, int rs);
    return issueValid && uses && (rs != 0) && writesReg(hist[0]) && (hist[0].rd == rs);
  endfunction

  function bit mReady();
    return !(mHazard(issueUsesRs1, int'(issueRs1)) || mHazard(issueUsesRs2, int'(issueRs2)));
  endfunction

  function logic [31:0] mBusy();
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < 3; k++) begin
        if (writesReg(hist[k]) && hist[k].rd == r) b[r] = 1'b1;
      end
    end
    return b;
  endfunction

  function int mCount(int maxVal);
    return (mStalls > maxVal) ? maxVal : mStalls;
  endfunction

  // Model state update mirrors what the pipeline must remember each cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
      mStalls = 0;
    end else begin
      bit rdy;
      rdy = mReady();
      if (issueValid && !rdy) mStalls = mStalls + 1;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{issueValid && rdy && !killEx, issueRegWrite, int'(issueRd)};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    checkOutput("issue_ready", 32'(ready16), 32'(mReady()));
    checkOutput("hazard_rs1", 32'(haz1_16), 32'(mHazard(issueUsesRs1, int'(issueRs1))));
    checkOutput("hazard_rs2", 32'(haz2_16), 32'(mHazard(issueUsesRs2, int'(issueRs2))));
    checkOutput("busy_vector", busy16, mBusy());
    checkOutput("stall_count16", 32'(stall16), 32'(mCount(65535)));
    checkOutput("issue_ready_w4", 32'(ready4), 32'(mReady()));
    checkOutput("busy_vector_w4", busy4, mBusy());
    checkOutput("hazard_w4", 32'({haz1_4, haz2_4}),
                32'({mHazard(issueUsesRs1, int'(issueRs1)), mHazard(issueUsesRs2, int'(issueRs2))}));
    checkOutput("stall_count4", 32'(stall4), 32'(mCount(15)));
  end

  // Drives one instruction slot for one cycle, just after the rising edge.
  task automatic applyStimulus(input bit v, input bit w, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit u1, input bit u2, input bit k);
    @(posedge clk);
    #1;
    issueValid    = v;
    issueRegWrite = w;
    issueRd       = rd;
    issueRs1      = rs1;
    issueRs2      = rs2;
    issueUsesRs1  = u1;
    issueUsesRs2  = u2;
    killEx        = k;
    #2;
  endtask

  initial begin
    issueValid = 0; issueRegWrite = 0; issueRd = 0; issueRs1 = 0; issueRs2 = 0;
    issueUsesRs1 = 0; issueUsesRs2 = 0; killEx = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    issueValid = 1; issueUsesRs1 = 1; issueRs1 = 5'd5;
    #1;
    checkOutput("reset issue_ready", 32'(ready16), 32'd1);
    checkOutput("reset hazard_rs1", 32'(haz1_16), 32'd0);
    checkOutput("reset busy_vector", busy16, 32'd0);
    checkOutput("reset stall_count", 32'(stall16), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    issueValid = 0; issueUsesRs1 = 0; issueRs1 = 0;

    // Back-to-back RAW on x5
    applyStimulus(1, 1, 5, 1, 2, 1, 1, 0);
    checkOutput("raw c1 ready", 32'(ready16), 32'd1);
    applyStimulus(1, 1, 6, 5, 1, 1, 1, 0);
    checkOutput("raw c2 ready", 32'(ready16), 32'd0);
    checkOutput("raw c2 hazard_rs1", 32'(haz1_16), 32'd1);
    checkOutput("raw c2 hazard_rs2", 32'(haz2_16), 32'd0);
    applyStimulus(1, 1, 6, 5, 1, 1, 1, 0);
    checkOutput("raw c3 ready", 32'(ready16), 32'd1);
    checkOutput("raw c3 busy5", 32'(busy16[5]), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw stall_count", 32'(stall16), 32'd1);
    checkOutput("raw busy6", 32'(busy16[6]), 32'd1);

    // Distance-2 consumer needs no stall
    applyStimulus(1, 1, 8, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 9, 1, 2, 1, 1, 0);
    checkOutput("dist2 unrelated ready", 32'(ready16), 32'd1);
    applyStimulus(1, 1, 20, 8, 8, 1, 1, 0);
    checkOutput("dist2 consumer ready", 32'(ready16), 32'd1);

    // x0 destination and non-writing producer
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 21, 0, 0, 1, 1, 0);
    checkOutput("x0 consumer ready", 32'(ready16), 32'd1);
    checkOutput("x0 busy0", 32'(busy16[0]), 32'd0);
    applyStimulus(1, 0, 10, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 22, 10, 10, 1, 1, 0);
    checkOutput("nowrite consumer ready", 32'(ready16), 32'd1);
    checkOutput("nowrite busy10", 32'(busy16[10]), 32'd0);

    // Killed producer leaves no trace
    applyStimulus(1, 1, 7, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 23, 7, 7, 1, 1, 0);
    checkOutput("kill consumer ready", 32'(ready16), 32'd1);
    checkOutput("kill busy7", 32'(busy16[7]), 32'd0);

    // Kill during a stall keeps the hazard visible
    applyStimulus(1, 1, 11, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 24, 1, 11, 1, 1, 1);
    checkOutput("kill+stall ready", 32'(ready16), 32'd0);
    checkOutput("kill+stall hazard_rs2", 32'(haz2_16), 32'd1);
    applyStimulus(1, 1, 24, 1, 11, 1, 1, 0);
    checkOutput("kill+stall retry ready", 32'(ready16), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("kill+stall busy24", 32'(busy16[24]), 32'd1);
    checkOutput("kill+stall busy11", 32'(busy16[11]), 32'd1);
    checkOutput("kill+stall stall_count", 32'(stall16), 32'd2);

    // Self-dependent x12 held in ID stalls every other cycle: 20 stalls
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 12, 12, 12, 1, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("saturated stall_count4", 32'(stall4), 32'd15);
    checkOutput("stall_count16 after loop", 32'(stall16), 32'd22);

    // Reset with three producers in flight
    applyStimulus(1, 1, 13, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 14, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 15, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("inflight busy", busy16, 32'h0000_E000);
    #1 rst = 1'b0;
    #1;
    checkOutput("midreset busy", busy16, 32'd0);
    checkOutput("midreset stall_count", 32'(stall16), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    issueValid = 1; issueRegWrite = 1; issueRd = 5'd25;
    issueRs1 = 5'd15; issueRs2 = 5'd14; issueUsesRs1 = 1; issueUsesRs2 = 1;
    #2;
    checkOutput("postreset consumer ready", 32'(ready16), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: Register_Scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating stall counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port issue_valid  input  1  ID stage holds a valid instruction.
REQ-005 SHALL have port issue_RegWrite  input  1  ID instruction writes a destination register.
REQ-006 SHALL have port issue_Rd  input  5  ID destination register.
REQ-007 SHALL have port issue_Rs1  input  5  ID first source register.
REQ-008 SHALL have port issue_Rs2  input  5  ID second source register.
REQ-009 SHALL have port issue_uses_rs1 / issue_uses_rs2  input  1 each  source actually read.
REQ-010 SHALL have port kill_ex  input  1  squash the instruction entering EX this cycle (taken branch/jump).
REQ-011 SHALL have port issue_ready  output  1  ID may advance to EX; 0 = stall PC and IF/ID.
REQ-012 SHALL have port hazard_rs1 / hazard_rs2  output  1 each  per-source hazard flag.
REQ-013 SHALL have port busy_vector  output  32  bit r set while any tracked write to xr is in flight.
REQ-014 SHALL have port stall_count  output  CNT_W  saturating count of stalled cycles.

Function
REQ-015 SHALL hold a 3-entry shadow pipeline (EX, MEM, WB); each entry = {valid, RegWrite, Rd}.
REQ-016 SHALL each cycle shift EX->MEM->WB and drop the old WB entry; no stall of EX/MEM/WB exists.
REQ-017 SHALL load EX with {issue_valid & issue_ready & ~kill_ex, issue_RegWrite, issue_Rd}; else load a bubble (valid=0).
REQ-018 SHALL treat an entry as a producer only if valid & RegWrite & Rd != 0.
REQ-019 SHALL assert hazard_rs1 combinationally when issue_valid & issue_uses_rs1 & Rs1 != 0 & Rs1 equals the EX-entry producer Rd; hazard_rs2 likewise.
REQ-020 SHALL not flag MEM or WB producers: operands come from the MEM/WB forwarding path one cycle later, or from the register file.
REQ-021 SHALL drive issue_ready = ~(hazard_rs1 | hazard_rs2); issue_ready = 1 when issue_valid = 0.
REQ-022 SHALL give each hazard exactly one stall cycle: the bubble enters EX, and the producer moves to MEM.
REQ-023 SHALL let kill_ex override a stall: the EX entry becomes a bubble, and issue_ready keeps its hazard value.
REQ-024 SHALL compute busy_vector as the OR of one-hot(Rd) over producer entries EX, MEM, WB; bit 0 is always 0.
REQ-025 SHALL increment stall_count on cycles with issue_valid & ~issue_ready, and saturate at all-ones.
REQ-026 SHALL handle the same Rd in several entries independently; busy clears only when the last entry leaves WB.

Reset
REQ-027 SHALL, on rst low, asynchronously clear all entry valid bits and stall_count to 0.
REQ-028 SHALL therefore show issue_ready = 1, hazard_rs1/2 = 0 and busy_vector = 0 during reset.
REQ-029 SHALL, when reset is asserted mid-stall, discard in-flight entries; the first post-reset cycle sees no hazards.
REQ-030 SHALL release reset synchronously to clk by external synchroniser; the block assumes a clean deassertion edge.

Structure
REQ-031 SHALL place REG_W=5, NUM_REGS=32, PIPE_DEPTH=3 and the entry struct type in shared package Pipeline_Pkg.
REQ-032 SHALL instantiate one sub-module Hazard_Compare: one producer entry plus one source -> match flag; use 2 instances on the EX entry.
REQ-033 SHALL keep the entry shift logic and the counter in the top module; there are no other sub-modules.

Verification
REQ-034 SHALL verify back-to-back RAW: issue add x5 then add x6,x5,x1 -> cycle 2 issue_ready=0, hazard_rs1=1; cycle 3 issue_ready=1; stall_count=1.
REQ-035 SHALL verify no stall at distance 2: issue x5 producer, an unrelated instruction, then a consumer of x5 -> issue_ready stays 1 throughout.
REQ-036 SHALL verify x0 and no-write cases: a producer with Rd=0 or RegWrite=0 followed by a consumer of the same register -> no hazard; busy_vector bit 0 = 0.
REQ-037 SHALL verify kill: issue x7 producer with kill_ex=1, then a consumer of x7 -> no hazard; busy_vector[7]=0.
REQ-038 SHALL verify saturation: CNT_W=4 with 20 stalled cycles -> stall_count=15.
REQ-039 SHALL verify reset mid-flight: 3 producers in flight, then rst low -> busy_vector=0 immediately; after release a consumer of any of them gets issue_ready=1.
